// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux_route stream demultiplexer.
package demux_pkg;

  localparam int ERR_CNT_W = 8;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_fill_e;

  // Select width for n destinations; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: registered output, 1 cycle latency, accepts a load
// while draining so a ready consumer sees full rate.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);

  typedef struct packed {
    slot_fill_e       fill;
    logic [WIDTH-1:0] data;
  } slot_state_t;

  slot_state_t r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '{fill: SLOT_EMPTY, data: '0};
    end else if (load) begin
      r_state.fill <= SLOT_FULL;
      r_state.data <= load_data;
    end else if ((r_state.fill == SLOT_FULL) && drain_ready) begin
      r_state.fill <= SLOT_EMPTY;
    end
  end

  assign valid      = (r_state.fill == SLOT_FULL);
  assign data       = r_state.data;
  // Bypass-on-drain: a slot being emptied this cycle can take the next beat.
  assign can_accept = (r_state.fill == SLOT_EMPTY) || drain_ready;

endmodule

// File: rtl/demux_route.sv
// 1-to-N demux: input >> SHIFT steered to a one-entry slot per port, 1 cycle latency.
// in_ready follows the selected slot; out-of-range selects never stall and are counted.
module demux_route
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 3,
  parameter int SHIFT = 3,
  parameter int SEL_W = sel_width(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   err_pulse,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [WIDTH-1:0]    w_shifted;
  logic [N_OUT-1:0]    w_can_accept;
  logic [N_OUT-1:0]    w_load;
  logic [SEL_SPAN-1:0] w_ready_span;
  logic                w_sel_ok;
  logic                w_accept;

  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_shifted = in_data >> SHIFT;
  assign w_sel_ok  = (int'(in_sel) < N_OUT);

  // Unused select codes read as ready so a bad destination is always swallowed.
  always_comb begin
    w_ready_span             = '1;
    w_ready_span[N_OUT-1:0]  = w_can_accept;
  end

  assign in_ready = w_ready_span[in_sel];
  assign w_accept = in_valid && in_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign w_load[k] = w_accept && w_sel_ok && (int'(in_sel) == k);

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (w_load[k]),
      .load_data  (w_shifted),
      .drain_ready(out_ready[k]),
      .valid      (out_valid[k]),
      .data       (out_data[k*WIDTH +: WIDTH]),
      .can_accept (w_can_accept[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_accept && !w_sel_ok;
      if (w_accept && !w_sel_ok && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
